// File: rtl/comp_seq.sv
// -----------------------------------------------------------------------------
// comp_seq : multi-cycle WIDTH-bit magnitude comparator (unsigned / signed).
//
// The operands are compared STEP bits per clock. The scan starts at the most
// significant chunk and works down to the least significant one. A start/done
// handshake is used, so wide compares need no long combinational chain.
//
// Parameters
//   WIDTH        operand width; must be a multiple of STEP and >= STEP
//   STEP         bits compared per clock (1, 2, 4 or 8)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        request a comparison (accepted only while idle)
//   signed_mode  1 = two's-complement compare, 0 = unsigned (sampled with start)
//   x, y         operands (sampled when start is accepted)
//   busy         comparison in progress
//   done         one-cycle completion pulse
//   gt, eq, lt   registered result flags. They are held until the next
//                accepted start. They read 0 while a compare is running.
//
// Build option
//   COMP_SEQ_EARLY_EXIT_EN : when defined, the scan ends on the first
//   differing chunk. When undefined, every compare takes WIDTH/STEP cycles.
// -----------------------------------------------------------------------------
module comp_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   LAST_IDX  = CW'(N - 1);
  // Mask of the top bit of a chunk. It is used to flip the sign bit.
  localparam logic [STEP-1:0] SIGN_FLIP = STEP'(1'b1) << (STEP - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    D_EQ = 2'b00,
    D_GT = 2'b01,
    D_LT = 2'b10
  } dec_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_signed;
  logic [CW-1:0]    r_cnt;
  dec_t             r_dec;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [STEP-1:0]  w_cx;
  logic [STEP-1:0]  w_cy;
  logic             w_chunk_gt;
  logic             w_chunk_lt;
  logic             w_last;
  logic             w_finish;
  dec_t             w_dec_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_gt_nxt;
  logic             w_eq_nxt;
  logic             w_lt_nxt;

  // The operand registers shift left by STEP on every RUN cycle. The chunk
  // currently being compared is therefore always the top STEP bits. In signed
  // mode, the sign bit is flipped on the first chunk only. That maps
  // two's-complement order onto unsigned order.
  always_comb begin
    w_cx = r_x[WIDTH-1 -: STEP];
    w_cy = r_y[WIDTH-1 -: STEP];
    if (r_signed && (r_cnt == {CW{1'b0}})) begin
      w_cx = w_cx ^ SIGN_FLIP;
      w_cy = w_cy ^ SIGN_FLIP;
    end else begin
      w_cx = w_cx;
      w_cy = w_cy;
    end
  end

  assign w_chunk_gt = (w_cx > w_cy);
  assign w_chunk_lt = (w_cx < w_cy);
  assign w_last     = (r_cnt == LAST_IDX);

  // Running decision: the first differing chunk sets it. Less significant
  // chunks never override a decision that is already made.
  always_comb begin
    w_dec_nxt = r_dec;
    case (r_dec)
      D_EQ: begin
        if (w_chunk_gt) begin
          w_dec_nxt = D_GT;
        end else if (w_chunk_lt) begin
          w_dec_nxt = D_LT;
        end else begin
          w_dec_nxt = D_EQ;
        end
      end
      D_GT:    w_dec_nxt = D_GT;
      D_LT:    w_dec_nxt = D_LT;
      default: w_dec_nxt = D_EQ;
    endcase
  end

`ifdef COMP_SEQ_EARLY_EXIT_EN
  // The scan can stop as soon as a decision appears. With early exit, the
  // decision is still "equal" whenever RUN is active, so any chunk that
  // differs here is the first one.
  assign w_finish = w_last | w_chunk_gt | w_chunk_lt;
`else
  assign w_finish = w_last;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_finish) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered handshake and result flags.
  always_comb begin
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    w_gt_nxt   = r_gt;
    w_eq_nxt   = r_eq;
    w_lt_nxt   = r_lt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy_nxt = 1'b1;
          w_gt_nxt   = 1'b0;
          w_eq_nxt   = 1'b0;
          w_lt_nxt   = 1'b0;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (w_finish) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
          w_gt_nxt   = (w_dec_nxt == D_GT);
          w_eq_nxt   = (w_dec_nxt == D_EQ);
          w_lt_nxt   = (w_dec_nxt == D_LT);
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_gt_nxt   = 1'b0;
        w_eq_nxt   = 1'b0;
        w_lt_nxt   = 1'b0;
      end
    endcase
  end

  // Operand capture, chunk shift, chunk counter and running decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x      <= {WIDTH{1'b0}};
      r_y      <= {WIDTH{1'b0}};
      r_signed <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_dec    <= D_EQ;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x      <= x;
            r_y      <= y;
            r_signed <= signed_mode;
            r_cnt    <= {CW{1'b0}};
            r_dec    <= D_EQ;
          end else begin
            r_cnt    <= {CW{1'b0}};
          end
        end
        S_RUN: begin
          r_x   <= r_x << STEP;
          r_y   <= r_y << STEP;
          r_dec <= w_dec_nxt;
          if (w_finish) begin
            r_cnt <= {CW{1'b0}};
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt <= {CW{1'b0}};
          r_dec <= D_EQ;
        end
      endcase
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_gt   <= w_gt_nxt;
      r_eq   <= w_eq_nxt;
      r_lt   <= w_lt_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule
